// File: rtl/fpga_dsp_pkg.sv
// Shared constants for the FPGA-to-DSP bus receive stage: register map,
// control/status bit positions and the status byte packing helper.
package fpga_dsp_pkg;

  localparam int BUS_W = 8;
  localparam int LVL_W = 4;

  localparam logic [BUS_W-1:0] DATA_ADDR = 8'h10;
  localparam logic [BUS_W-1:0] CTRL_ADDR = 8'h11;
  localparam logic [BUS_W-1:0] STAT_ADDR = 8'h12;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  localparam int STAT_OVF    = 7;
  localparam int STAT_FULL   = 6;
  localparam int STAT_EMPTY  = 5;
  localparam int STAT_LVL_HI = 3;
  localparam int STAT_LVL_LO = 0;

  function automatic logic [BUS_W-1:0] pack_status(input logic ovf,
                                                   input logic full,
                                                   input logic empty,
                                                   input logic [LVL_W-1:0] level);
    logic [BUS_W-1:0] s;
    s                          = '0;
    s[STAT_OVF]                = ovf;
    s[STAT_FULL]               = full;
    s[STAT_EMPTY]              = empty;
    s[STAT_LVL_HI:STAT_LVL_LO] = level;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head is visible on rdata_o while not empty.
// Occupancy is tracked in its own counter so full/empty never need pointer tricks.
module sync_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Flush beats a same-cycle pop; a pop on a full FIFO makes room for the push.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale entries from rdata_o.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpga_dsp_bus_rx.sv
// Bus receive stage: decodes master writes into FIFO pushes and control actions,
// streams the FIFO head to the DSP, and answers status reads one cycle later.
module fpga_dsp_bus_rx
  import fpga_dsp_pkg::*;
#(
  parameter int               DEPTH     = 8,
  parameter logic [BUS_W-1:0] DATA_ADDR = fpga_dsp_pkg::DATA_ADDR,
  parameter logic [BUS_W-1:0] CTRL_ADDR = fpga_dsp_pkg::CTRL_ADDR,
  parameter logic [BUS_W-1:0] STAT_ADDR = fpga_dsp_pkg::STAT_ADDR
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             BusWr,
  input  logic             BusRd,
  input  logic [BUS_W-1:0] AddrBus,
  input  logic [BUS_W-1:0] DataBus,
  output logic [BUS_W-1:0] RdData,
  output logic             RdValid,
  output logic [BUS_W-1:0] DIn,
  output logic             DInValid,
  input  logic             DInReady,
  output logic             Overflow,
  output logic [LVL_W-1:0] Level
);

  logic wr_data, wr_ctrl, rd_req;
  logic flush, clr_ovf, pop, ovf_set;
  logic full, empty;

  logic             ovf_q, ovf_d;
  logic             rd_valid_q, rd_valid_d;
  logic [BUS_W-1:0] rd_data_q, rd_data_d;

  assign wr_data = BusWr & (AddrBus == DATA_ADDR);
  assign wr_ctrl = BusWr & (AddrBus == CTRL_ADDR);
  assign rd_req  = BusRd & ~BusWr;
  assign flush   = wr_ctrl & DataBus[CTRL_FLUSH];
  assign clr_ovf = wr_ctrl & DataBus[CTRL_CLR_OVF];
  assign pop     = DInValid & DInReady;
  // A data write and a flush never share a cycle, so only the pop can rescue a full push.
  assign ovf_set = wr_data & full & ~pop;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (BUS_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .push_i  (wr_data),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (DataBus),
    .rdata_o (DIn),
    .full_o  (full),
    .empty_o (empty),
    .level_o (Level)
  );

  assign DInValid = ~empty;
  assign Overflow = ovf_q;
  assign RdData   = rd_data_q;
  assign RdValid  = rd_valid_q;

  always_comb begin
    ovf_d      = ovf_q;
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    if (clr_ovf)      ovf_d = 1'b0;
    else if (ovf_set) ovf_d = 1'b1;
    if (rd_req) begin
      rd_data_d = (AddrBus == STAT_ADDR) ? pack_status(ovf_q, full, empty, Level) : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_fpga_dsp_bus_rx.sv
// Bench for fpga_dsp_bus_rx: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the register map and FIFO.
module tb_fpga_dsp_bus_rx;

  logic       Clk = 1'b0;
  logic       Rst_n, BusWr, BusRd, DInReady;
  logic [7:0] AddrBus, DataBus;
  logic [7:0] RdData, DIn;
  logic       RdValid, DInValid, Overflow;
  logic [3:0] Level;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_rdv;
  logic [7:0] m_rdd;

  always #5 Clk = ~Clk;

  fpga_dsp_bus_rx dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .BusWr    (BusWr),
    .BusRd    (BusRd),
    .AddrBus  (AddrBus),
    .DataBus  (DataBus),
    .RdData   (RdData),
    .RdValid  (RdValid),
    .DIn      (DIn),
    .DInValid (DInValid),
    .DInReady (DInReady),
    .Overflow (Overflow),
    .Level    (Level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step(input bit rst, input bit wr, input bit rd,
                            input logic [7:0] addr, input logic [7:0] data, input bit rdy);
    int  sz;
    bit  flush, clr, push;
    if (!rst) begin
      m_q.delete();
      m_ovf = 0;
      m_rdv = 0;
      m_rdd = 8'h00;
      return;
    end
    sz    = m_q.size();
    flush = wr && addr == 8'h11 && data[0];
    clr   = wr && addr == 8'h11 && data[1];
    push  = wr && addr == 8'h10;
    m_rdv = rd && !wr;
    if (m_rdv) m_rdd = (addr == 8'h12) ? {m_ovf, sz == 8, sz == 0, 1'b0, 4'(sz)} : 8'h00;
    if (flush) m_q.delete();
    else begin
      if (sz > 0 && rdy) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 8) m_q.push_back(data);
        else m_ovf = 1;
      end
    end
    if (clr) m_ovf = 0;
  endtask

  task automatic compare_all();
    check("din",      DIn,      (m_q.size() != 0) ? m_q[0] : 8'h00);
    check("dinvalid", DInValid, m_q.size() != 0);
    check("level",    Level,    m_q.size());
    check("overflow", Overflow, m_ovf);
    check("rdvalid",  RdValid,  m_rdv);
    check("rddata",   RdData,   m_rdd);
  endtask

  task automatic cycle(input bit rst, input bit wr, input bit rd,
                       input logic [7:0] addr, input logic [7:0] data, input bit rdy);
    Rst_n = rst; BusWr = wr; BusRd = rd; AddrBus = addr; DataBus = data; DInReady = rdy;
    @(posedge Clk);
    #1;
    model_step(rst, wr, rd, addr, data, rdy);
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    cycle(1, 0, 0, 8'h00, 8'h00, rdy);
  endtask

  initial begin
    Rst_n = 0; BusWr = 0; BusRd = 0; AddrBus = 0; DataBus = 0; DInReady = 0;

    // Reset held with a data write pending: nothing may be pushed.
    cycle(0, 1, 0, 8'h10, 8'h55, 0);
    cycle(0, 1, 0, 8'h10, 8'h55, 0);
    check("t1_level", Level, 4'd0);
    check("t1_dinvalid", DInValid, 1'b0);
    idle(0);

    // Single push then pop.
    cycle(1, 1, 0, 8'h10, 8'hA5, 0);
    check("t2_din", DIn, 8'hA5);
    check("t2_level", Level, 4'd1);
    idle(1);
    check("t2_empty", DInValid, 1'b0);

    // Nine pushes into eight slots, then drain in order.
    for (int i = 1; i <= 9; i++) cycle(1, 1, 0, 8'h10, 8'(i), 0);
    check("t3_level", Level, 4'd8);
    check("t3_ovf", Overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain", DIn, 32'(i));
      idle(1);
    end
    check("t3_drained", DInValid, 1'b0);

    // Clear overflow, fill, then push while popping at full.
    cycle(1, 1, 0, 8'h11, 8'h02, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'h10, 8'(8'h20 + i), 0);
    cycle(1, 1, 0, 8'h10, 8'hEE, 1);
    check("t4_level", Level, 4'd8);
    check("t4_ovf", Overflow, 1'b0);
    check("t4_head", DIn, 8'h21);

    // Reach level 5 with overflow set, then flush and clear together.
    cycle(1, 1, 0, 8'h10, 8'hFF, 0);
    for (int i = 0; i < 3; i++) idle(1);
    check("t5_pre_level", Level, 4'd5);
    check("t5_pre_ovf", Overflow, 1'b1);
    cycle(1, 1, 0, 8'h11, 8'h03, 1);
    check("t5_level", Level, 4'd0);
    check("t5_dinvalid", DInValid, 1'b0);
    check("t5_ovf", Overflow, 1'b0);

    // Status reads.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 8'h10, 8'(8'h30 + i), 0);
    cycle(1, 0, 1, 8'h12, 8'h00, 0);
    check("t6_rdvalid", RdValid, 1'b1);
    check("t6_rddata", RdData, 8'h03);
    idle(0);
    check("t6_pulse", RdValid, 1'b0);
    check("t6_hold", RdData, 8'h03);
    cycle(1, 0, 1, 8'h20, 8'h00, 0);
    check("t6_unmapped", RdData, 8'h00);
    cycle(1, 1, 1, 8'h12, 8'h00, 0);
    check("t6_rdwr", RdValid, 1'b0);

    // Random traffic in blocks with varying drain pressure.
    for (int blk = 0; blk < 15; blk++) begin
      int bias = $urandom_range(1, 3);
      for (int n = 0; n < 200; n++) begin
        bit         rst, wr, rd, rdy;
        logic [7:0] addr, data;
        rst  = ($urandom_range(0, 299) != 0);
        wr   = ($urandom_range(0, 7) < 5);
        rd   = ($urandom_range(0, 2) == 0);
        rdy  = ($urandom_range(0, 3) < bias);
        data = 8'($urandom);
        case ($urandom_range(0, 7))
          0, 1, 2, 3: addr = 8'h10;
          4: begin
            addr    = 8'h11;
            data[0] = ($urandom_range(0, 3) == 0);
          end
          5, 6: addr = 8'h12;
          default: addr = 8'($urandom);
        endcase
        cycle(rst, wr, rd, addr, data, rdy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
